// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: operation codes, op-class encodings and funct7 patterns.
// The base (funct7 = 0x00) operation for each funct3 is provided as a helper.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SLL = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_SUB = 4'b0110,
    ALU_EQ  = 4'b1000,
    ALU_SRA = 4'b1010,
    ALU_SLT = 4'b1100
  } alu_op_e;

  localparam logic [1:0] ALU_CLASS_MEM    = 2'b00;
  localparam logic [1:0] ALU_CLASS_BRANCH = 2'b01;
  localparam logic [1:0] ALU_CLASS_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_CLASS_ITYPE  = 2'b11;

  localparam logic [6:0] FUNCT7_BASE = 7'h00;
  localparam logic [6:0] FUNCT7_ALT  = 7'h20;

  // funct3  011 has no entry; callers must treat it as illegal before using this.
  function automatic alu_op_e base_op(input logic [2:0] funct3);
    alu_op_e op;
    case (funct3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Pure combinational decode of {op class, funct3, funct7} into the ALU Operation code.
// Encodings with no ALU meaning raise illegal and report Operation 0000.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] op_class,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_op_e    operation,
  output logic       illegal
);

  logic f7_base;
  logic f7_alt;

  assign f7_base = (funct7 == FUNCT7_BASE);
  assign f7_alt  = (funct7 == FUNCT7_ALT);

  always_comb begin
    operation = ALU_AND;
    illegal   = 1'b0;
    case (op_class)
      ALU_CLASS_MEM: operation = ALU_ADD;
      ALU_CLASS_BRANCH: begin
        case (funct3[2:1])
          2'b00:   operation = ALU_EQ;
          2'b10:   operation = ALU_SLT;
          default: illegal   = 1'b1;
        endcase
      end
      default: begin
        // R-type and I-type share one table; only funct3 000 differs (I-type ignores funct7).
        case (funct3)
          3'b000: begin
            if (op_class == ALU_CLASS_ITYPE || f7_base) operation = ALU_ADD;
            else if (f7_alt)                            operation = ALU_SUB;
            else                                        illegal   = 1'b1;
          end
          3'b101: begin
            if (f7_base)     operation = ALU_SRL;
            else if (f7_alt) operation = ALU_SRA;
            else             illegal   = 1'b1;
          end
          3'b011: illegal = 1'b1;
          default: begin
            if (f7_base) operation = base_op(funct3);
            else         illegal   = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_op_issue.sv
// ID/EX issue register: decodes the ALU operation, selects operands and hands one micro-op
// per valid/ready transfer to the ALU. ALU_ISSUE_SKID_EN adds a one-entry skid buffer.
//
// Handshake: a transfer happens on a rising edge where valid && ready; a producer holding
// valid must keep its payload stable until the transfer. flush wins over every transfer.
module alu_op_issue
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               alu_op_class,
  input  logic [2:0]               funct3,
  input  logic [6:0]               funct7,
  input  logic                     alu_src,
  input  logic [DATA_WIDTH-1:0]    rs1_data,
  input  logic [DATA_WIDTH-1:0]    rs2_data,
  input  logic [DATA_WIDTH-1:0]    imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     illegal
);

  alu_op_e                  dec_op;
  logic                     dec_illegal;
  logic [DATA_WIDTH-1:0]    src_b_sel;
  logic [OPCODE_LENGTH-1:0] dec_code;
  logic                     in_fire;

  alu_op_decode u_decode (
    .op_class  (alu_op_class),
    .funct3    (funct3),
    .funct7    (funct7),
    .operation (dec_op),
    .illegal   (dec_illegal)
  );

  assign src_b_sel = alu_src ? imm : rs2_data;
  assign dec_code  = OPCODE_LENGTH'(dec_op);

`ifdef ALU_ISSUE_SKID_EN
  logic                     skid_valid;
  logic [DATA_WIDTH-1:0]    skid_a;
  logic [DATA_WIDTH-1:0]    skid_b;
  logic [OPCODE_LENGTH-1:0] skid_op;
  logic                     skid_illegal;
  logic                     in_ready_q;

  // Registered ready breaks the out_ready -> in_ready path; the skid absorbs the extra accept.
  assign in_ready = in_ready_q;
  assign in_fire  = in_valid && in_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      SrcA         <= '0;
      SrcB         <= '0;
      Operation    <= '0;
      illegal      <= 1'b0;
      skid_valid   <= 1'b0;
      skid_a       <= '0;
      skid_b       <= '0;
      skid_op      <= '0;
      skid_illegal <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else if (!out_valid || out_ready) begin
      // Output slot frees up: the older skid entry goes first to keep order.
      if (skid_valid) begin
        out_valid  <= 1'b1;
        SrcA       <= skid_a;
        SrcB       <= skid_b;
        Operation  <= skid_op;
        illegal    <= skid_illegal;
        skid_valid <= 1'b0;
        in_ready_q <= 1'b1;
      end else if (in_fire) begin
        out_valid <= 1'b1;
        SrcA      <= rs1_data;
        SrcB      <= src_b_sel;
        Operation <= dec_code;
        illegal   <= dec_illegal;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_valid   <= 1'b1;
      skid_a       <= rs1_data;
      skid_b       <= src_b_sel;
      skid_op      <= dec_code;
      skid_illegal <= dec_illegal;
      in_ready_q   <= 1'b0;
    end
  end
`else
  logic out_fire;

  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      SrcA      <= '0;
      SrcB      <= '0;
      Operation <= '0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      SrcA      <= rs1_data;
      SrcB      <= src_b_sel;
      Operation <= dec_code;
      illegal   <= dec_illegal;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_issue.sv
// Randomized bench for alu_op_issue against a queue-based model of held micro-ops.
// Build with +define+ALU_ISSUE_SKID_EN to exercise the skid configuration.
module tb_alu_op_issue;

  localparam int W  = 32;
  localparam int PW = 1 + 4 + W + W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    alu_op_class;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic          alu_src;
  logic [W-1:0]  rs1_data;
  logic [W-1:0]  rs2_data;
  logic [W-1:0]  imm;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  SrcA;
  logic [W-1:0]  SrcB;
  logic [3:0]    Operation;
  logic          illegal;

  int n_checks = 0;
  int n_errors = 0;

  // Held micro-ops, oldest first: {illegal, Operation, SrcA, SrcB}.
  logic [PW-1:0] exp_q[$];

  alu_op_issue #(.DATA_WIDTH(W), .OPCODE_LENGTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_op_class (alu_op_class),
    .funct3       (funct3),
    .funct7       (funct7),
    .alu_src      (alu_src),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .imm          (imm),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .SrcA         (SrcA),
    .SrcB         (SrcB),
    .Operation    (Operation),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Returns {illegal, code} straight from the instruction-level rules.
  function automatic logic [4:0] ref_decode(input logic [1:0] cls, input logic [2:0] f3,
                                            input logic [6:0] f7);
    logic [3:0] tbl [8];
    logic       alt_ok;
    tbl = '{4'b0010, 4'b0011, 4'b1100, 4'b0000, 4'b0100, 4'b0101, 4'b0001, 4'b0000};
    if (cls == 2'b00) return {1'b0, 4'b0010};
    if (cls == 2'b01) begin
      if (f3 == 3'd0 || f3 == 3'd1) return {1'b0, 4'b1000};
      if (f3 == 3'd4 || f3 == 3'd5) return {1'b0, 4'b1100};
      return {1'b1, 4'b0000};
    end
    if (f3 == 3'd3) return {1'b1, 4'b0000};
    if (cls == 2'b11 && f3 == 3'd0) return {1'b0, 4'b0010};
    if (f7 == 7'h00) return {1'b0, tbl[f3]};
    alt_ok = (f3 == 3'd5) || (f3 == 3'd0 && cls == 2'b10);
    if (f7 == 7'h20 && alt_ok) return {1'b0, (f3 == 3'd0) ? 4'b0110 : 4'b1010};
    return {1'b1, 4'b0000};
  endfunction

  function automatic logic exp_in_ready();
`ifdef ALU_ISSUE_SKID_EN
    return exp_q.size() < 2;
`else
    return exp_q.size() == 0 || out_ready;
`endif
  endfunction

  // Called at a negedge with inputs already set; ends at the following negedge.
  task automatic step();
    logic          rdy;
    logic          in_fire;
    logic          out_fire;
    logic [4:0]    d;
    logic [PW-1:0] item;
    #1;
    rdy = exp_in_ready();
    check("in_ready", PW'(in_ready), PW'(rdy));
    @(posedge clk);
    in_fire  = in_valid && rdy;
    out_fire = (exp_q.size() > 0) && out_ready;
    d    = ref_decode(alu_op_class, funct3, funct7);
    item = {d[4], d[3:0], rs1_data, alu_src ? imm : rs2_data};
    if (flush) exp_q.delete();
    else begin
      if (out_fire) void'(exp_q.pop_front());
      if (in_fire) exp_q.push_back(item);
    end
    @(negedge clk);
    check("out_valid", PW'(out_valid), PW'(exp_q.size() > 0));
    if (exp_q.size() > 0)
      check("payload", {illegal, Operation, SrcA, SrcB}, exp_q[0]);
  endtask

  task automatic set_op(input logic v, input logic [1:0] cls, input logic [2:0] f3,
                        input logic [6:0] f7, input logic asrc, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] im);
    in_valid = v; alu_op_class = cls; funct3 = f3; funct7 = f7;
    alu_src = asrc; rs1_data = a; rs2_data = b; imm = im;
  endtask

  task automatic set_random();
    in_valid     = ($urandom_range(0, 9) < 7);
    alu_op_class = 2'($urandom_range(0, 3));
    funct3       = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 3))
      0, 1:    funct7 = 7'h00;
      2:       funct7 = 7'h20;
      default: funct7 = 7'($urandom);
    endcase
    alu_src   = 1'($urandom);
    rs1_data  = $urandom;
    rs2_data  = $urandom;
    imm       = $urandom;
    out_ready = ($urandom_range(0, 9) < 6);
    flush     = ($urandom_range(0, 19) == 0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    set_op(1'b0, 2'b00, 3'd0, 7'h00, 1'b0, '0, '0, '0);
    repeat (2) @(negedge clk);
    check("rst_out_valid", PW'(out_valid), '0);
    check("rst_payload", {illegal, Operation, SrcA, SrcB}, '0);
    rst_n = 1'b1;

    // SUB, then check constants directly.
    out_ready = 1'b1;
    set_op(1'b1, 2'b10, 3'b000, 7'h20, 1'b0, 32'd5, 32'd3, 32'd99);
    step();
    check("t1_sub", {illegal, Operation, SrcA, SrcB}, {1'b0, 4'b0110, 32'd5, 32'd3});

    set_op(1'b1, 2'b11, 3'b101, 7'h20, 1'b1, 32'd7, 32'd8, 32'd4);
    step();
    check("t2_srai", {illegal, Operation, SrcB}, PW'({1'b0, 4'b1010, 32'd4}));
    set_op(1'b1, 2'b11, 3'b101, 7'h40, 1'b1, 32'd7, 32'd8, 32'd4);
    step();
    check("t2_bad_f7", PW'({illegal, Operation}), PW'({1'b1, 4'b0000}));

    set_op(1'b1, 2'b01, 3'b100, 7'h00, 1'b0, 32'd1, 32'd2, 32'd0);
    step();
    check("t3_blt", PW'({illegal, Operation}), PW'({1'b0, 4'b1100}));
    set_op(1'b1, 2'b10, 3'b011, 7'h00, 1'b0, 32'd1, 32'd2, 32'd0);
    step();
    check("t3_sltu", PW'({illegal, Operation}), PW'({1'b1, 4'b0000}));

    // Backpressure with a stream of distinct micro-ops, then drain.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_op(1'b1, 2'b10, 3'b100, 7'h00, 1'b0, 32'(100 + i), 32'(200 + i), 32'd0);
      step();
    end
    set_op(1'b0, 2'b00, 3'd0, 7'h00, 1'b0, '0, '0, '0);
    out_ready = 1'b1;
    repeat (3) step();

    // Flush beats a stalled output and a same-cycle input.
    out_ready = 1'b0;
    set_op(1'b1, 2'b00, 3'd0, 7'h00, 1'b0, 32'h11, 32'h22, 32'd0);
    step();
    flush = 1'b1;
    set_op(1'b1, 2'b10, 3'b111, 7'h00, 1'b0, 32'h33, 32'h44, 32'd0);
    step();
    check("t5_flush", PW'(out_valid), '0);
    flush = 1'b0; out_ready = 1'b1;
    set_op(1'b0, 2'b00, 3'd0, 7'h00, 1'b0, '0, '0, '0);
    repeat (2) step();

    // Async reset in the middle of a stall, away from any clock edge.
    out_ready = 1'b0;
    set_op(1'b1, 2'b10, 3'b001, 7'h00, 1'b0, 32'h55, 32'h66, 32'd0);
    repeat (2) step();
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", PW'(out_valid), '0);
    check("t6_rst_payload", {illegal, Operation, SrcA, SrcB}, '0);
    exp_q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    set_op(1'b1, 2'b10, 3'b110, 7'h00, 1'b0, 32'h77, 32'h88, 32'd0);
    step();
    check("t6_recover", {illegal, Operation, SrcA, SrcB}, {1'b0, 4'b0001, 32'h77, 32'h88});

    for (int i = 0; i < 400; i++) begin
      set_random();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
